// File: rtl/stereo_win_pkg.sv
// Shared widths, window payload types and skid-buffer states for the stereo window reader.
package stereo_win_pkg;

  localparam int unsigned IMG_W_DEF = 640;
  localparam int unsigned IMG_H_DEF = 480;
  localparam int unsigned WIN_DEF   = 5;
  localparam int unsigned PIX_W_DEF = 8;

  localparam int unsigned X_W      = 10;
  localparam int unsigned Y_W      = 9;
  localparam int unsigned ROW_BITS = WIN_DEF * PIX_W_DEF;
  localparam int unsigned WIN_BITS = WIN_DEF * ROW_BITS;

  typedef logic [WIN_BITS-1:0] win_t;

  typedef struct packed {
    win_t           l;
    win_t           r;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } win_tag_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/win_skid_buf.sv
// Two-entry skid buffer for tagged windows; upstream never stalls, so a push into a full
// buffer without a pop is dropped and latched as overflow.
module win_skid_buf
  import stereo_win_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     push,
  input  win_tag_t din,
  input  logic     ready,
  output logic     valid,
  output win_tag_t dout,
  output logic     overflow,
  output logic [1:0] fill
);

  skid_state_t state, state_d;
  win_tag_t    head, tail;
  logic        pop;
  logic        ld_head, head_from_tail, ld_tail, ovf_set;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_d;
  end

  // Next state and entry load controls; flush overrides everything.
  always_comb begin
    state_d        = state;
    ld_head        = 1'b0;
    head_from_tail = 1'b0;
    ld_tail        = 1'b0;
    ovf_set        = 1'b0;
    pop            = (state != EMPTY) && ready;
    case (state)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          ld_head = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          ld_head = 1'b1;
        end else if (push) begin
          state_d = TWO;
          ld_tail = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (push && pop) begin
          ld_head        = 1'b1;
          head_from_tail = 1'b1;
          ld_tail        = 1'b1;
        end else if (pop) begin
          state_d        = ONE;
          ld_head        = 1'b1;
          head_from_tail = 1'b1;
        end else if (push) begin
          ovf_set = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      ld_head = 1'b0;
      ld_tail = 1'b0;
      ovf_set = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (ld_head) head <= head_from_tail ? tail : din;
      if (ld_tail) tail <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
  end

  assign valid = (state != EMPTY);
  assign fill  = state;
  assign dout  = head;

endmodule

// File: rtl/line_window_reader.sv
// Consumer side of the stereo line-buffer window interface: realigns the pixel strobe,
// tracks image position, and forwards border-valid tagged windows through a skid buffer.
module line_window_reader
  import stereo_win_pkg::*;
#(
  parameter int unsigned IMG_W   = IMG_W_DEF,
  parameter int unsigned IMG_H   = IMG_H_DEF,
  parameter int unsigned WIN     = WIN_DEF,
  parameter int unsigned PIX_W   = PIX_W_DEF,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clken,
  input  logic                     i_frame_start,
  input  logic [WIN*PIX_W-1:0]     i_vec_l_1,
  input  logic [WIN*PIX_W-1:0]     i_vec_l_2,
  input  logic [WIN*PIX_W-1:0]     i_vec_l_3,
  input  logic [WIN*PIX_W-1:0]     i_vec_l_4,
  input  logic [WIN*PIX_W-1:0]     i_vec_l_5,
  input  logic [WIN*PIX_W-1:0]     i_vec_r_1,
  input  logic [WIN*PIX_W-1:0]     i_vec_r_2,
  input  logic [WIN*PIX_W-1:0]     i_vec_r_3,
  input  logic [WIN*PIX_W-1:0]     i_vec_r_4,
  input  logic [WIN*PIX_W-1:0]     i_vec_r_5,
  output logic                     o_win_valid,
  input  logic                     i_win_ready,
  output logic [WIN*WIN*PIX_W-1:0] o_win_l,
  output logic [WIN*WIN*PIX_W-1:0] o_win_r,
  output logic [X_W-1:0]           o_x,
  output logic [Y_W-1:0]           o_y,
  output logic                     o_line_done,
  output logic                     o_frame_done,
  output logic                     o_overflow,
  output logic [1:0]               o_fill
);

  localparam int unsigned HALF = (WIN - 1) / 2;

  if (IMG_W > 1024 || IMG_H > 512) begin : g_bad_img_size
    $error("line_window_reader: IMG_W must be <= 1024 and IMG_H <= 512");
  end
  if (WIN != WIN_DEF || PIX_W != PIX_W_DEF) begin : g_bad_win_shape
    $error("line_window_reader: WIN/PIX_W must match stereo_win_pkg");
  end
  if (RAM_LAT < 1 || IMG_W < WIN || IMG_H < WIN) begin : g_bad_cfg
    $error("line_window_reader: RAM_LAT >= 1 and image at least one window");
  end

  logic [RAM_LAT-1:0] dly;
  logic               samp, push, last_col, last_row;
  logic [X_W-1:0]     col;
  logic [Y_W-1:0]     row;
  win_tag_t           din, head;

  // Strobe delay line matching the line-buffer read latency.
  always_ff @(posedge clk) begin
    if (rst || i_frame_start) dly <= '0;
    else                      dly <= RAM_LAT'({dly, i_clken});
  end

  assign samp     = dly[RAM_LAT-1];
  assign last_col = (col == X_W'(IMG_W - 1));
  assign last_row = (row == Y_W'(IMG_H - 1));
  assign push     = samp && (col >= X_W'(WIN - 1)) && (row >= Y_W'(WIN - 1));

  always_ff @(posedge clk) begin
    if (rst || i_frame_start) begin
      col <= '0;
      row <= '0;
    end else if (samp) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + Y_W'(1);
      end else begin
        col <= col + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_frame_start) begin
      o_line_done  <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_line_done  <= samp && last_col;
      o_frame_done <= samp && last_col && last_row;
    end
  end

  // Tag uses the pre-increment position; centre is HALF behind the newest sample.
  always_comb begin
    din   = '0;
    din.l = {i_vec_l_5, i_vec_l_4, i_vec_l_3, i_vec_l_2, i_vec_l_1};
    din.r = {i_vec_r_5, i_vec_r_4, i_vec_r_3, i_vec_r_2, i_vec_r_1};
    din.x = col - X_W'(HALF);
    din.y = row - Y_W'(HALF);
  end

  win_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (i_frame_start),
    .push     (push),
    .din      (din),
    .ready    (i_win_ready),
    .valid    (o_win_valid),
    .dout     (head),
    .overflow (o_overflow),
    .fill     (o_fill)
  );

  assign o_win_l = head.l;
  assign o_win_r = head.r;
  assign o_x     = head.x;
  assign o_y     = head.y;

endmodule
